osc_voice_mixer: RTL and testbench



---
 rtl/osc_voice_mixer.sv | 125 ++++++++++++
 tb/tb_osc_voice_mixer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osc_voice_mixer.sv
// osc_voice_mixer: scales each oscillator slot by its level and sums per voice.
// Optional OSC_MIX_SAT_EN: clamp mix_out instead of two's-complement wrap.
module osc_voice_mixer #(
  parameter int VOICES  = 8,
  parameter int V_OSC   = 4,
  parameter int V_WIDTH = 3,
  parameter int O_WIDTH = 2
) (
  input  logic               sCLK_XVXOSC,
  input  logic               iRST,
  input  logic signed [16:0] sample_in,
  input  logic               sample_vld,
  input  logic [V_WIDTH-1:0] vx_in,
  input  logic [O_WIDTH-1:0] ox_in,
  input  logic               lvl_wr,
  input  logic [O_WIDTH-1:0] lvl_adr,
  input  logic [7:0]         lvl_data,
  input  logic               err_clr,
  output logic signed [16:0] mix_out,
  output logic               mix_vld,
  output logic [V_WIDTH-1:0] mix_vx,
  output logic               seq_err
);

  localparam logic [O_WIDTH-1:0] OX_LAST = O_WIDTH'(V_OSC - 1);

  typedef struct packed {
    logic               vld;
    logic [V_WIDTH-1:0] vx;
    logic [O_WIDTH-1:0] ox;
    logic signed [16:0] scaled;
  } s1_t;

  logic [7:0]         lvl [V_OSC];
  s1_t                s1;
  logic signed [25:0] prod;

  logic signed [18:0] acc;
  logic [O_WIDTH-1:0] exp_ox;
  logic [V_WIDTH-1:0] grp_vx;
  logic               group_ok;

  logic signed [18:0] add_in;
  logic signed [18:0] acc_nxt;
  logic [V_WIDTH-1:0] gvx_nxt;
  logic [O_WIDTH-1:0] exp_nxt;
  logic               first;
  logic               vx_bad;
  logic               bad;
  logic               ok_nxt;
  logic               err_set;
  logic               emit;
  logic signed [16:0] mix_d;

  // Level is zero-extended so 255 stays a positive gain.
  assign prod = sample_in * $signed({1'b0, lvl[ox_in]});

  always_comb begin
    first   = s1.ox == '0;
    vx_bad  = int'(s1.vx) >= VOICES;
    add_in  = {{2{s1.scaled[16]}}, s1.scaled};
    acc_nxt = first ? add_in : acc + add_in;
    gvx_nxt = first ? s1.vx : grp_vx;
    exp_nxt = O_WIDTH'((int'(s1.ox) + 1) % V_OSC);
    if (first) begin
      bad    = (exp_ox != '0) || vx_bad;
      ok_nxt = !vx_bad;
    end else begin
      bad    = (s1.ox != exp_ox) || (s1.vx != grp_vx) || vx_bad;
      ok_nxt = group_ok && !bad;
    end
    err_set = s1.vld && bad;
    emit    = s1.vld && (s1.ox == OX_LAST) && ok_nxt;
  end

`ifdef OSC_MIX_SAT_EN
  always_comb begin
    unique case (1'b1)
      acc_nxt > 19'sd65535:  mix_d = 17'sh0ffff;
      acc_nxt < -19'sd65536: mix_d = 17'sh10000;
      default:               mix_d = acc_nxt[16:0];
    endcase
  end
`else
  assign mix_d = acc_nxt[16:0];
`endif

  always_ff @(posedge sCLK_XVXOSC) begin
    if (iRST) begin
      for (int i = 0; i < V_OSC; i++) lvl[i] <= '0;
      s1       <= '0;
      acc      <= '0;
      exp_ox   <= '0;
      grp_vx   <= '0;
      group_ok <= 1'b0;
      mix_out  <= '0;
      mix_vld  <= 1'b0;
      mix_vx   <= '0;
      seq_err  <= 1'b0;
    end else begin
      if (lvl_wr) lvl[lvl_adr] <= lvl_data;
      s1.vld <= sample_vld;
      if (sample_vld) begin
        s1.vx     <= vx_in;
        s1.ox     <= ox_in;
        s1.scaled <= 17'(prod >>> 8);
      end
      mix_vld <= 1'b0;
      if (s1.vld) begin
        acc      <= acc_nxt;
        exp_ox   <= exp_nxt;
        grp_vx   <= gvx_nxt;
        group_ok <= ok_nxt;
        if (emit) begin
          mix_vld <= 1'b1;
          mix_out <= mix_d;
          mix_vx  <= gvx_nxt;
        end
      end
      if (err_set) seq_err <= 1'b1;
      else if (err_clr) seq_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_osc_voice_mixer.sv
// tb_osc_voice_mixer: random + directed stimulus against a slot-list model.
// Builds with or without OSC_MIX_SAT_EN.
module tb_osc_voice_mixer;

  localparam int V_OSC = 4;
`ifdef OSC_MIX_SAT_EN
  localparam int EXP_POS = 65535;
  localparam int EXP_NEG = -65536;
`else
  localparam int EXP_POS = -1028;
  localparam int EXP_NEG = 1024;
`endif

  logic               sCLK_XVXOSC = 1'b0;
  logic               iRST = 1'b1;
  logic signed [16:0] sample_in = '0;
  logic               sample_vld = 1'b0;
  logic [2:0]         vx_in = '0;
  logic [1:0]         ox_in = '0;
  logic               lvl_wr = 1'b0;
  logic [1:0]         lvl_adr = '0;
  logic [7:0]         lvl_data = '0;
  logic               err_clr = 1'b0;
  logic signed [16:0] mix_out;
  logic               mix_vld;
  logic [2:0]         mix_vx;
  logic               seq_err;

  osc_voice_mixer dut (
    .sCLK_XVXOSC(sCLK_XVXOSC),
    .iRST(iRST),
    .sample_in(sample_in),
    .sample_vld(sample_vld),
    .vx_in(vx_in),
    .ox_in(ox_in),
    .lvl_wr(lvl_wr),
    .lvl_adr(lvl_adr),
    .lvl_data(lvl_data),
    .err_clr(err_clr),
    .mix_out(mix_out),
    .mix_vld(mix_vld),
    .mix_vx(mix_vx),
    .seq_err(seq_err)
  );

  always #5 sCLK_XVXOSC = ~sCLK_XVXOSC;

  int n_chk = 0;
  int n_fail = 0;
  int n_emit = 0;

  function automatic void chk(string nm, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endfunction

  function automatic int fold(int s);
    int w;
    w = s & 32'h1ffff;
`ifdef OSC_MIX_SAT_EN
    if (s > 65535) return 65535;
    if (s < -65536) return -65536;
    return s;
`else
    return (w >= 65536) ? w - 131072 : w;
`endif
  endfunction

  // Reference: slots since the last ox==0 form the current group.
  typedef struct {
    int ox;
    int vx;
    int sc;
  } slot_t;

  slot_t grp[$];
  int    lvl_m[V_OSC];
  int    last_ox = V_OSC - 1;
  int    gvx = 0;
  bit    d_emit = 0;
  bit    d_err = 0;
  int    d_out = 0;
  int    d_vx = 0;
  int    e_out = 0;
  int    e_vx = 0;
  bit    e_vld = 0;
  bit    e_err = 0;

  function automatic bit group_ok();
    if (grp.size() == 0 || grp[0].ox != 0) return 0;
    foreach (grp[i])
      if (grp[i].ox != i || grp[i].vx != grp[0].vx) return 0;
    return 1;
  endfunction

  function automatic int group_sum();
    int s = 0;
    foreach (grp[i]) s += grp[i].sc;
    return s;
  endfunction

  always @(posedge sCLK_XVXOSC) begin
    int ox, vx, sc, ex;
    if (iRST) begin
      foreach (lvl_m[i]) lvl_m[i] = 0;
      grp.delete();
      last_ox = V_OSC - 1;
      gvx = 0;
      d_emit = 0;
      d_err = 0;
      e_out = 0;
      e_vx = 0;
      e_vld = 0;
      e_err = 0;
    end else begin
      e_vld = d_emit;
      if (d_emit) begin
        e_out = d_out;
        e_vx = d_vx;
        n_emit++;
      end
      if (d_err) e_err = 1;
      else if (err_clr) e_err = 0;
      d_emit = 0;
      d_err = 0;
      if (sample_vld) begin
        ox = int'(ox_in);
        vx = int'(vx_in);
        sc = (int'(sample_in) * lvl_m[ox]) >>> 8;
        ex = (last_ox + 1) % V_OSC;
        if (ox == 0) begin
          d_err = (ex != 0);
          gvx = vx;
          grp.delete();
        end else begin
          d_err = (ox != ex) || (vx != gvx);
        end
        grp.push_back('{ox: ox, vx: vx, sc: sc});
        last_ox = ox;
        if (ox == V_OSC - 1 && group_ok()) begin
          d_emit = 1;
          d_out = fold(group_sum());
          d_vx = gvx;
        end
      end
      if (lvl_wr) lvl_m[int'(lvl_adr)] = int'(lvl_data);
    end
  end

  always @(negedge sCLK_XVXOSC) begin
    chk("mix_vld", int'(mix_vld), int'(e_vld));
    chk("mix_out", int'(mix_out), e_out);
    chk("mix_vx", int'(mix_vx), e_vx);
    chk("seq_err", int'(seq_err), int'(e_err));
  end

  task automatic idle(input int n);
    repeat (n) @(negedge sCLK_XVXOSC);
  endtask

  task automatic wr_all(input int d);
    for (int a = 0; a < V_OSC; a++) begin
      lvl_wr = 1'b1;
      lvl_adr = 2'(a);
      lvl_data = 8'(d);
      @(negedge sCLK_XVXOSC);
    end
    lvl_wr = 1'b0;
  endtask

  task automatic slot(input bit v, input int vx, input int ox, input int s);
    sample_vld = v;
    vx_in = 3'(vx);
    ox_in = 2'(ox);
    sample_in = 17'(s);
    @(negedge sCLK_XVXOSC);
    sample_vld = 1'b0;
  endtask

  task automatic group(input int vx, input int s);
    for (int o = 0; o < V_OSC; o++) slot(1'b1, vx, o, s);
  endtask

  initial begin
    int cx = 0;
    int cv = 0;
    idle(2);
    iRST = 1'b0;
    chk("rst_out", int'(mix_out), 0);
    chk("rst_err", int'(seq_err), 0);

    wr_all(128);
    group(2, 1000);
    chk("lat_n1_vld", int'(mix_vld), 0);
    idle(1);
    chk("basic_vld", int'(mix_vld), 1);
    chk("basic_vx", int'(mix_vx), 2);
    chk("basic_out", int'(mix_out), 2000);
    chk("basic_err", int'(seq_err), 0);

    wr_all(255);
    group(1, 65535);
    idle(1);
    chk("pos_full", int'(mix_out), EXP_POS);
    group(1, -65536);
    idle(1);
    chk("neg_full", int'(mix_out), EXP_NEG);

    wr_all(128);
    slot(1'b1, 3, 0, 200);
    slot(1'b1, 3, 1, 200);
    slot(1'b1, 3, 3, 200);
    group(3, 200);
    idle(1);
    chk("bad_grp_err", int'(seq_err), 1);
    chk("good_after_bad", int'(mix_out), 400);
    err_clr = 1'b1;
    @(negedge sCLK_XVXOSC);
    err_clr = 1'b0;
    chk("err_clr", int'(seq_err), 0);

    wr_all(64);
    slot(1'b1, 5, 0, 400);
    lvl_wr = 1'b1;
    lvl_adr = 2'd1;
    lvl_data = 8'd0;
    slot(1'b1, 5, 1, 400);
    lvl_wr = 1'b0;
    slot(1'b1, 5, 2, 400);
    slot(1'b1, 5, 3, 400);
    idle(1);
    chk("lvl_old", int'(mix_out), 400);
    group(5, 400);
    idle(1);
    chk("lvl_new", int'(mix_out), 300);

    wr_all(128);
    for (int o = 0; o < V_OSC; o++) begin
      slot(1'b1, 4, o, 256);
      if (o < V_OSC - 1) slot(1'b0, 4, o, 0);
    end
    idle(1);
    chk("gap_vld", int'(mix_vld), 1);
    chk("gap_out", int'(mix_out), 512);

    slot(1'b1, 6, 2, 1000);
    slot(1'b1, 6, 0, 1000);
    chk("pre_rst_err", int'(seq_err), 1);
    slot(1'b1, 6, 1, 1000);
    iRST = 1'b1;
    @(negedge sCLK_XVXOSC);
    iRST = 1'b0;
    chk("mid_rst_out", int'(mix_out), 0);
    chk("mid_rst_vx", int'(mix_vx), 0);
    chk("mid_rst_err", int'(seq_err), 0);
    idle(2);
    chk("mid_rst_nostrobe", int'(mix_vld), 0);
    wr_all(128);
    group(7, 1000);
    idle(1);
    chk("post_rst_out", int'(mix_out), 2000);
    chk("post_rst_vx", int'(mix_vx), 7);

    for (int i = 0; i < 3000; i++) begin
      iRST = ($urandom_range(0, 599) == 0);
      err_clr = ($urandom_range(0, 49) == 0);
      lvl_wr = ($urandom_range(0, 9) == 0);
      lvl_adr = 2'($urandom);
      lvl_data = 8'($urandom);
      sample_vld = ($urandom_range(0, 9) < 7);
      sample_in = 17'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        ox_in = 2'($urandom);
        vx_in = 3'($urandom);
      end else begin
        ox_in = 2'(cx);
        vx_in = 3'(cv);
      end
      if (sample_vld) begin
        cx = (cx + 1) % V_OSC;
        if (cx == 0) cv = $urandom_range(0, 7);
      end
      @(negedge sCLK_XVXOSC);
    end
    iRST = 1'b0;
    sample_vld = 1'b0;
    lvl_wr = 1'b0;
    err_clr = 1'b0;
    idle(4);
    chk("emits_seen", int'(n_emit > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
